// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the default reset fetch address and the word-address helpers.
package fetch_unit_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Default fetch address after reset
  localparam logic [31:0] FU_RESET_PC = 32'h0000_0000;

  // Byte distance between consecutive instruction words
  localparam logic [31:0] WORD_INC = 32'd4;

  // Next sequential word address; wraps modulo 2^32
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + WORD_INC;
  endfunction

  // Redirect targets are forced onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid buffer that parks a returned instruction word and its
// address while decode is stalled.
module fetch_hold_buffer
  import fetch_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din_data,
  input  logic [31:0] din_addr,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] addr
);

  // Occupancy flag: reset and clear empty the entry, load fills it
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload capture; contents are meaningless while valid is low
  always_ff @(posedge CLK) begin
    if (load && !clear) begin
      data <= din_data;
      addr <= din_addr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory,
// presents one registered instruction per cycle to decode, absorbs a
// single stalled word in a hold buffer and handles branch redirects,
// draining any request that was already in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FU_RESET_PC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DATA,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC4
);

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] drain_addr;

  logic        consume;
  logic        in_req;
  logic        in_full;
  logic [31:0] br_pc;

  logic        buf_load;
  logic        buf_clear;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [31:0] buf_addr;

  assign consume = IR_VALID & ~STALL;
  assign in_req  = (state == ST_REQ);
  assign in_full = (state == ST_FULL);
  assign br_pc   = align_word(BR_TARGET);

  // A request is outstanding in REQ and while draining a redirected fetch;
  // the drain keeps presenting the abandoned address until memory answers.
  assign MEM_REQ  = in_req | (state == ST_DRAIN);
  assign MEM_ADDR = (state == ST_DRAIN) ? drain_addr : fetch_pc;

  assign PC4 = next_word(PC);

  // Park the returned word when decode holds a live IR and refuses it
  assign buf_load  = in_req & ~BR_TAKEN & MEM_ACK & IR_VALID & STALL;
  assign buf_clear = BR_TAKEN | (in_full & consume);

  fetch_hold_buffer u_hold (
    .CLK      (CLK),
    .RST      (RST),
    .load     (buf_load),
    .clear    (buf_clear),
    .din_data (MEM_DATA),
    .din_addr (fetch_pc),
    .valid    (buf_valid),
    .data     (buf_data),
    .addr     (buf_addr)
  );

  // Fetch FSM together with fetch_pc and the registered IR/PC/IR_VALID
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      IR         <= 32'h0;
      PC         <= 32'h0;
      IR_VALID   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (BR_TAKEN) begin
            fetch_pc <= br_pc;
            IR_VALID <= 1'b0;
          end
          state <= ST_REQ;
        end

        ST_REQ: begin
          if (BR_TAKEN) begin
            // Redirect wins over any ack or stall in the same cycle
            fetch_pc <= br_pc;
            IR_VALID <= 1'b0;
            if (!MEM_ACK) begin
              drain_addr <= fetch_pc;
              state      <= ST_DRAIN;
            end
          end else if (MEM_ACK) begin
            fetch_pc <= next_word(fetch_pc);
            if (!IR_VALID || consume) begin
              IR       <= MEM_DATA;
              PC       <= fetch_pc;
              IR_VALID <= 1'b1;
            end else begin
              state <= ST_FULL;
            end
          end else if (consume) begin
            IR_VALID <= 1'b0;
          end
        end

        ST_FULL: begin
          if (BR_TAKEN) begin
            fetch_pc <= br_pc;
            IR_VALID <= 1'b0;
            state    <= ST_REQ;
          end else if (consume && buf_valid) begin
            IR    <= buf_data;
            PC    <= buf_addr;
            state <= ST_REQ;
          end
        end

        ST_DRAIN: begin
          // Data returned for the abandoned address is dropped
          if (BR_TAKEN) begin
            fetch_pc <= br_pc;
          end
          if (MEM_ACK) begin
            state <= ST_REQ;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
